miriscv_lsu_ooo: RTL and testbench

Next-generation load/store unit for the miriscv core with a decoupled request/grant/response data interface and up to OUTSTANDING in-flight transactions. It sits between the decode/execute stage and data memory. It produces byte enables and replicated write data, tracks pending accesses in an internal response FIFO, and returns sign/zero-extended load data tagged with its destination register. It replaces the single-outstanding LSU so the pipeline can issue back-to-back memory accesses without waiting for each response.

---
 rtl/miriscv_lsu_ooo.sv | 186 ++++++++++++++++++
 tb/tb_miriscv_lsu_ooo.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_lsu_ooo.sv
// miriscv_lsu_ooo -- load/store unit with up to OUTSTANDING in-flight
// transactions on a request/grant/response data bus.
//
// Optional feature macro: MIRISCV_LSU_MISALIGN_TRAP_EN
//   defined   : misaligned requests are dropped and lsu_misalign_o pulses
//   undefined : misaligned addresses are aligned down to the access size
//
// Ports
//   clk_i, arstn_i          clock, async active-low reset
//   lsu_req_i/kill_i/we_i   core request, same-cycle kill, store flag
//   lsu_size_i              funct3 access size (B/H/W/BU/HU)
//   lsu_addr_i/data_i/rd_i  byte address, right-aligned store data, load tag
//   lsu_stall_o             request present but not accepted
//   lsu_rvalid_o/rdata_o/rd_o  registered load result and its tag
//   lsu_misalign_o          registered misaligned-access pulse
//   lsu_busy_o, lsu_outstanding_o  in-flight status
//   data_*                  memory-side request/grant/response bus
module miriscv_lsu_ooo #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned OUTSTANDING    = 2,
    parameter int unsigned GPR_ADDR_WIDTH = 5
) (
    input  logic                               clk_i,
    input  logic                               arstn_i,
    input  logic                               lsu_req_i,
    input  logic                               lsu_kill_i,
    input  logic                               lsu_we_i,
    input  logic [2:0]                         lsu_size_i,
    input  logic [XLEN-1:0]                    lsu_addr_i,
    input  logic [XLEN-1:0]                    lsu_data_i,
    input  logic [GPR_ADDR_WIDTH-1:0]          lsu_rd_i,
    output logic                               lsu_stall_o,
    output logic                               lsu_rvalid_o,
    output logic [XLEN-1:0]                    lsu_rdata_o,
    output logic [GPR_ADDR_WIDTH-1:0]          lsu_rd_o,
    output logic                               lsu_misalign_o,
    output logic                               lsu_busy_o,
    output logic [$clog2(OUTSTANDING+1)-1:0]   lsu_outstanding_o,
    output logic                               data_req_o,
    input  logic                               data_gnt_i,
    output logic                               data_we_o,
    output logic [XLEN/8-1:0]                  data_be_o,
    output logic [XLEN-1:0]                    data_addr_o,
    output logic [XLEN-1:0]                    data_wdata_o,
    input  logic                               data_rvalid_i,
    input  logic [XLEN-1:0]                    data_rdata_i
);

    localparam int unsigned CW = $clog2(OUTSTANDING + 1);
    localparam int unsigned PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

    // One pending transaction: enough to route and extend its response
    typedef struct packed {
        logic                      we;
        logic [2:0]                size;
        logic [1:0]                off;
        logic [GPR_ADDR_WIDTH-1:0] rd;
    } rsp_entry_t;

    rsp_entry_t        fifo_q [OUTSTANDING];
    logic [PW-1:0]     wptr_q;
    logic [PW-1:0]     rptr_q;
    logic [CW-1:0]     count_q;

    logic              is_h;
    logic              is_w;
    logic [1:0]        off;
    logic              trap;
    logic              issue;
    logic              accept;
    logic              pop;
    rsp_entry_t        head;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   ext_data;
    logic              head_signed;

    // Sizes 000/100 are bytes, 001/101 halves, everything with bit 1 set is a word
    assign is_h = (lsu_size_i[1:0] == 2'b01);
    assign is_w = lsu_size_i[1];

`ifdef MIRISCV_LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = (is_h & lsu_addr_i[0]) | (is_w & (lsu_addr_i[1:0] != 2'b00));
    assign trap       = misaligned;
    assign off        = lsu_addr_i[1:0];

    // Trap pulse, one cycle after the offending request
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            lsu_misalign_o <= 1'b0;
        end else begin
            lsu_misalign_o <= lsu_req_i & ~lsu_kill_i & misaligned;
        end
    end
`else
    // Misaligned accesses are silently aligned down to the access size
    assign trap           = 1'b0;
    assign off            = is_w ? 2'b00 : (is_h ? {lsu_addr_i[1], 1'b0} : lsu_addr_i[1:0]);
    assign lsu_misalign_o = 1'b0;
`endif

    assign issue  = lsu_req_i & ~lsu_kill_i & ~trap & (count_q < CW'(OUTSTANDING));
    assign accept = issue & data_gnt_i;
    assign pop    = data_rvalid_i & (count_q != '0);

    assign lsu_stall_o       = lsu_req_i & ~lsu_kill_i & ~accept & ~trap;
    assign lsu_busy_o        = (count_q != '0);
    assign lsu_outstanding_o = count_q;

    // Bus request payload, held at zero while nothing is issued
    always_comb begin
        data_req_o   = issue;
        data_we_o    = 1'b0;
        data_be_o    = '0;
        data_addr_o  = '0;
        data_wdata_o = '0;
        if (issue) begin
            data_we_o   = lsu_we_i;
            data_addr_o = {lsu_addr_i[XLEN-1:2], 2'b00};
            if (is_w) begin
                data_be_o    = 4'b1111;
                data_wdata_o = lsu_data_i;
            end else if (is_h) begin
                data_be_o    = 4'b0011 << off;
                data_wdata_o = {2{lsu_data_i[15:0]}};
            end else begin
                data_be_o    = 4'b0001 << off;
                data_wdata_o = {4{lsu_data_i[7:0]}};
            end
        end
    end

    // Align the returned word to the head entry's byte offset and extend
    assign head        = fifo_q[rptr_q];
    assign head_signed = ~head.size[2];
    assign shifted     = data_rdata_i >> {head.off, 3'b000};

    always_comb begin
        ext_data = shifted;
        if (!head.size[1]) begin
            if (head.size[0]) begin
                ext_data = {{16{head_signed & shifted[15]}}, shifted[15:0]};
            end else begin
                ext_data = {{24{head_signed & shifted[7]}}, shifted[7:0]};
            end
        end
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    // Response FIFO, in-flight count and registered load result
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            lsu_rvalid_o <= 1'b0;
            lsu_rdata_o  <= '0;
            lsu_rd_o     <= '0;
            for (int i = 0; i < int'(OUTSTANDING); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                fifo_q[wptr_q] <= '{we: lsu_we_i, size: lsu_size_i, off: off, rd: lsu_rd_i};
                wptr_q         <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            count_q      <= count_q + CW'(accept) - CW'(pop);
            lsu_rvalid_o <= pop & ~head.we;
            if (pop & ~head.we) begin
                lsu_rdata_o <= ext_data;
                lsu_rd_o    <= head.rd;
            end
        end
    end

    rvalid_without_pending: assert property (@(posedge clk_i) disable iff (!arstn_i)
        !(data_rvalid_i && (count_q == '0)))
        else $error("lsu: data_rvalid_i with no outstanding transaction");

endmodule

// File: tb/tb_miriscv_lsu_ooo.sv
module tb_miriscv_lsu_ooo;

    logic        clk_i;
    logic        arstn_i;
    logic        lsu_req_i;
    logic        lsu_kill_i;
    logic        lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_data_i;
    logic [4:0]  lsu_rd_i;
    logic        lsu_stall_o;
    logic        lsu_rvalid_o;
    logic [31:0] lsu_rdata_o;
    logic [4:0]  lsu_rd_o;
    logic        lsu_misalign_o;
    logic        lsu_busy_o;
    logic [1:0]  lsu_outstanding_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    int errors = 0;
    int checks = 0;

    miriscv_lsu_ooo #(.XLEN(32), .OUTSTANDING(2), .GPR_ADDR_WIDTH(5)) dut (
        .clk_i(clk_i), .arstn_i(arstn_i),
        .lsu_req_i(lsu_req_i), .lsu_kill_i(lsu_kill_i), .lsu_we_i(lsu_we_i),
        .lsu_size_i(lsu_size_i), .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
        .lsu_rd_i(lsu_rd_i), .lsu_stall_o(lsu_stall_o), .lsu_rvalid_o(lsu_rvalid_o),
        .lsu_rdata_o(lsu_rdata_o), .lsu_rd_o(lsu_rd_o), .lsu_misalign_o(lsu_misalign_o),
        .lsu_busy_o(lsu_busy_o), .lsu_outstanding_o(lsu_outstanding_o),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_we_o(data_we_o),
        .data_be_o(data_be_o), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Reference view of one in-flight transaction
    typedef struct {
        logic       we;
        logic [2:0] size;
        logic [1:0] off;
        logic [4:0] rd;
    } ent_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input logic we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] data, input logic [4:0] rd);
        lsu_req_i  = 1'b1;
        lsu_kill_i = 1'b0;
        lsu_we_i   = we;
        lsu_size_i = size;
        lsu_addr_i = addr;
        lsu_data_i = data;
        lsu_rd_i   = rd;
    endtask

    task automatic idle();
        lsu_req_i  = 1'b0;
        lsu_kill_i = 1'b0;
        lsu_we_i   = 1'b0;
    endtask

    task automatic rsp(input logic [31:0] d);
        data_rvalid_i = 1'b1;
        data_rdata_i  = d;
    endtask

    // Spec-level extension: pick the addressed lane, then sign/zero extend
    function automatic logic [31:0] ref_ext(input logic [2:0] size, input logic [1:0] off,
                                            input logic [31:0] d);
        int unsigned v;
        v = d >> (8 * off);
        case (size)
            3'b000: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            3'b100: v = v % 256;
            3'b001: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            3'b101: v = v % 65536;
            default: v = d;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] ref_be(input logic [2:0] size, input logic [1:0] off);
        int unsigned m;
        if (size[1]) m = 15;
        else if (size[0]) m = 3 << off;
        else m = 1 << off;
        return m;
    endfunction

    ent_t        q[$];
    ent_t        h;
    logic        pend;
    logic [31:0] pend_data;
    logic [4:0]  pend_rd;
    logic        held;
    logic        can;
    logic [31:0] a;
    logic [2:0]  sizes [5];
    logic [1:0]  roff;

    initial begin
        sizes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        arstn_i = 1'b0;
        idle();
        lsu_size_i = '0; lsu_addr_i = '0; lsu_data_i = '0; lsu_rd_i = '0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
        #2;
        check("rst_req", data_req_o, 0);
        check("rst_be", data_be_o, 0);
        check("rst_stall", lsu_stall_o, 0);
        check("rst_rvalid", lsu_rvalid_o, 0);
        check("rst_rdata", lsu_rdata_o, 0);
        check("rst_rd", lsu_rd_o, 0);
        check("rst_outst", lsu_outstanding_o, 0);
        check("rst_busy", lsu_busy_o, 0);
        check("rst_misalign", lsu_misalign_o, 0);
        step();
        arstn_i = 1'b1;
        data_gnt_i = 1'b1;
        step();

        // LW at 0x100, response two cycles after issue
        set_req(1'b0, 3'b010, 32'h100, 32'h0, 5'd5);
        settle();
        check("lw_req", data_req_o, 1);
        check("lw_be", data_be_o, 4'hF);
        check("lw_addr", data_addr_o, 32'h100);
        check("lw_we", data_we_o, 0);
        check("lw_stall", lsu_stall_o, 0);
        step(); idle();
        check("lw_outst", lsu_outstanding_o, 1);
        check("lw_busy", lsu_busy_o, 1);
        step();
        rsp(32'hDEADBEEF);
        step(); data_rvalid_i = 1'b0;
        check("lw_rvalid", lsu_rvalid_o, 1);
        check("lw_rdata", lsu_rdata_o, 32'hDEADBEEF);
        check("lw_rd", lsu_rd_o, 5);
        check("lw_outst0", lsu_outstanding_o, 0);
        step();
        check("lw_pulse", lsu_rvalid_o, 0);

        // LB / LBU at 0x103
        set_req(1'b0, 3'b000, 32'h103, 32'h0, 5'd9);
        settle();
        check("lb_be", data_be_o, 4'b1000);
        step(); idle(); rsp(32'h80000000);
        step(); data_rvalid_i = 1'b0;
        check("lb_rdata", lsu_rdata_o, 32'hFFFFFF80);
        check("lb_rd", lsu_rd_o, 9);
        set_req(1'b0, 3'b100, 32'h103, 32'h0, 5'd10);
        step(); idle(); rsp(32'h80000000);
        step(); data_rvalid_i = 1'b0;
        check("lbu_rdata", lsu_rdata_o, 32'h00000080);

        // SH at 0x202
        set_req(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 5'd0);
        settle();
        check("sh_be", data_be_o, 4'b1100);
        check("sh_wdata", data_wdata_o, 32'hABCDABCD);
        check("sh_we", data_we_o, 1);
        check("sh_addr", data_addr_o, 32'h200);
        step(); idle(); rsp(32'h0);
        step(); data_rvalid_i = 1'b0;
        check("sh_no_rvalid", lsu_rvalid_o, 0);
        check("sh_outst", lsu_outstanding_o, 0);

        // Three back-to-back LWs against a two-deep FIFO
        set_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd1);
        step();
        set_req(1'b0, 3'b010, 32'h14, 32'h0, 5'd2);
        settle();
        check("b2b_req2", data_req_o, 1);
        step();
        set_req(1'b0, 3'b010, 32'h18, 32'h0, 5'd3);
        settle();
        check("b2b_stall", lsu_stall_o, 1);
        check("b2b_req3", data_req_o, 0);
        check("b2b_outst", lsu_outstanding_o, 2);
        step();
        rsp(32'h11111111);
        settle();
        check("b2b_stall_rv", lsu_stall_o, 1);
        step(); data_rvalid_i = 1'b0;
        settle();
        check("b2b_r1_valid", lsu_rvalid_o, 1);
        check("b2b_r1_data", lsu_rdata_o, 32'h11111111);
        check("b2b_r1_rd", lsu_rd_o, 1);
        check("b2b_req3_now", data_req_o, 1);
        check("b2b_stall_now", lsu_stall_o, 0);
        step(); idle(); rsp(32'h22222222);
        check("b2b_outst_full", lsu_outstanding_o, 2);
        step(); rsp(32'h33333333);
        check("b2b_r2_rd", lsu_rd_o, 2);
        check("b2b_r2_data", lsu_rdata_o, 32'h22222222);
        step(); data_rvalid_i = 1'b0;
        check("b2b_r3_rd", lsu_rd_o, 3);
        check("b2b_r3_data", lsu_rdata_o, 32'h33333333);
        check("b2b_outst0", lsu_outstanding_o, 0);

        // Same-cycle accept and response at count 1
        set_req(1'b0, 3'b010, 32'h40, 32'h0, 5'd7);
        step();
        set_req(1'b0, 3'b010, 32'h44, 32'h0, 5'd8);
        rsp(32'h77);
        settle();
        check("sc_req", data_req_o, 1);
        step(); idle(); data_rvalid_i = 1'b0;
        check("sc_outst", lsu_outstanding_o, 1);
        check("sc_rd", lsu_rd_o, 7);
        check("sc_rdata", lsu_rdata_o, 32'h77);
        rsp(32'h88);
        step(); data_rvalid_i = 1'b0;
        check("sc_rd2", lsu_rd_o, 8);
        check("sc_outst0", lsu_outstanding_o, 0);

        // Killed request
        set_req(1'b0, 3'b010, 32'h50, 32'h0, 5'd4);
        lsu_kill_i = 1'b1;
        settle();
        check("kill_req", data_req_o, 0);
        check("kill_stall", lsu_stall_o, 0);
        step(); idle();
        check("kill_outst", lsu_outstanding_o, 0);

        // Misaligned LW at 0x101
        set_req(1'b0, 3'b010, 32'h101, 32'h0, 5'd6);
        settle();
`ifdef MIRISCV_LSU_MISALIGN_TRAP_EN
        check("mis_req", data_req_o, 0);
        check("mis_stall", lsu_stall_o, 0);
        step(); idle();
        check("mis_pulse", lsu_misalign_o, 1);
        check("mis_outst", lsu_outstanding_o, 0);
        step();
        check("mis_pulse_end", lsu_misalign_o, 0);
`else
        check("mis_req", data_req_o, 1);
        check("mis_addr", data_addr_o, 32'h100);
        check("mis_be", data_be_o, 4'hF);
        step(); idle();
        check("mis_flag", lsu_misalign_o, 0);
        check("mis_outst", lsu_outstanding_o, 1);
        rsp(32'hCAFEF00D);
        step(); data_rvalid_i = 1'b0;
        check("mis_rdata", lsu_rdata_o, 32'hCAFEF00D);
`endif

        // No grant: request stalls and nothing is pushed
        set_req(1'b0, 3'b010, 32'h60, 32'h0, 5'd2);
        data_gnt_i = 1'b0;
        settle();
        check("nogrant_stall", lsu_stall_o, 1);
        check("nogrant_req", data_req_o, 1);
        step();
        check("nogrant_outst", lsu_outstanding_o, 0);
        data_gnt_i = 1'b1;
        step(); idle(); rsp(32'h5);
        step(); data_rvalid_i = 1'b0;
        check("nogrant_rdata", lsu_rdata_o, 32'h5);

        // Reset while a transaction is in flight clears the FIFO
        set_req(1'b0, 3'b010, 32'h70, 32'h0, 5'd1);
        step(); idle();
        arstn_i = 1'b0;
        settle();
        check("rstmid_outst", lsu_outstanding_o, 0);
        check("rstmid_busy", lsu_busy_o, 0);
        step();
        arstn_i = 1'b1;
        step();

        // Randomized traffic against a queue model
        pend = 1'b0; pend_data = '0; pend_rd = '0; held = 1'b0;
        for (int cyc = 0; cyc < 2010; cyc++) begin
            check("rnd_rvalid", lsu_rvalid_o, pend);
            if (pend) begin
                check("rnd_rdata", lsu_rdata_o, pend_data);
                check("rnd_rd", lsu_rd_o, pend_rd);
            end
            check("rnd_outst", lsu_outstanding_o, 32'(q.size()));
            check("rnd_misalign", lsu_misalign_o, 0);
            if (!held) begin
                lsu_req_i  = ($urandom_range(0, 3) != 0);
                lsu_kill_i = 1'b0;
                lsu_size_i = sizes[$urandom_range(0, 4)];
                roff = 2'($urandom_range(0, 3));
                if (lsu_size_i[1]) roff = 2'b00;
                else if (lsu_size_i[0]) roff[0] = 1'b0;
                a = $urandom();
                a[1:0] = roff;
                lsu_addr_i = a;
                lsu_we_i   = ($urandom_range(0, 2) == 0);
                lsu_data_i = $urandom();
                lsu_rd_i   = 5'($urandom_range(0, 31));
            end
            data_gnt_i    = ($urandom_range(0, 3) != 0);
            data_rvalid_i = (q.size() != 0) && ($urandom_range(0, 1) == 1);
            data_rdata_i  = $urandom();
            if (cyc >= 2000) begin
                idle();
                data_rvalid_i = (q.size() != 0);
            end
            settle();
            can = lsu_req_i && (q.size() < 2);
            check("rnd_req", data_req_o, can);
            check("rnd_stall", lsu_stall_o, lsu_req_i && !(can && data_gnt_i));
            if (can) begin
                a = lsu_addr_i;
                a[1:0] = 2'b00;
                check("rnd_be", data_be_o, ref_be(lsu_size_i, lsu_addr_i[1:0]));
                check("rnd_addr", data_addr_o, a);
            end
            held = lsu_req_i && !(can && data_gnt_i);
            pend = 1'b0;
            if (data_rvalid_i) begin
                h = q.pop_front();
                if (!h.we) begin
                    pend      = 1'b1;
                    pend_data = ref_ext(h.size, h.off, data_rdata_i);
                    pend_rd   = h.rd;
                end
            end
            if (can && data_gnt_i) begin
                q.push_back('{we: lsu_we_i, size: lsu_size_i, off: lsu_addr_i[1:0], rd: lsu_rd_i});
            end
            step();
        end
        data_rvalid_i = 1'b0;
        check("rnd_final_rvalid", lsu_rvalid_o, pend);
        check("rnd_final_outst", lsu_outstanding_o, 32'(q.size()));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
